// File: rtl/alu_sequencer.sv
// alu_sequencer: round-robin arbiter that sequences two requesters onto one shared external ALU
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res,
    output logic       carry,
    output logic       busy,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic       alu_s2,
    input  logic [3:0] alu_res,
    input  logic       alu_carry
);
    typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;
    state_t state, state_nx;
    logic ptr, owner;
    logic [3:0] cnt;
    logic [2:0] op_r;
    logic [3:0] a_r, b_r;
    logic grant1, done;
    assign grant1 = req1 & (~req0 | ptr);
    assign done = cnt == 4'(SETTLE_CYCLES - 1);
    assign alu_a = a_r;
    assign alu_b = b_r;
    assign {alu_s0, alu_s1, alu_s2} = op_r;
    // next state and decoded status outputs
    always_comb begin
        state_nx = IDLE;
        ack0 = 1'b0;
        ack1 = 1'b0;
        busy = state != IDLE;
        state_nx = (state == IDLE) ? ((req0 | req1) ? SETTLE : IDLE) :
                   (state == SETTLE) ? (done ? ACK : SETTLE) : IDLE;
        ack0 = state == ACK && !owner;
        ack1 = state == ACK && owner;
    end
    // state register, operand latch, settle counter, result capture and priority pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 1'b0;
            owner <= 1'b0;
            cnt <= 4'd0;
            op_r <= 3'd0;
            a_r <= 4'd0;
            b_r <= 4'd0;
            res <= 4'd0;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 | req1)) begin
                owner <= grant1;
                op_r <= grant1 ? op1 : op0;
                a_r <= grant1 ? a1 : a0;
                b_r <= grant1 ? b1 : b0;
                cnt <= 4'd0;
            end
            if (state == SETTLE) begin
                cnt <= cnt + 4'd1;
                if (done) begin
                    res <= alu_res;
                    carry <= ~op_r[2] & alu_carry;
                end
            end
            if (state == ACK) ptr <= ~ptr;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized transaction-level check of alu_sequencer against a round-robin/ALU reference
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic req0, req1, q0, q1;
    logic [2:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic ack0, ack1, carry, busy, s0, s1, s2, alu_carry;
    logic [3:0] res, alu_a, alu_b, alu_res;
    logic ack0_4, ack1_4, carry_4, busy_4, s0_4, s1_4, s2_4, alu_carry_4;
    logic [3:0] res_4, alu_a_4, alu_b_4, alu_res_4;
    int n_cmp = 0;
    int n_bad = 0;
    bit ptr_m;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'd2: return {1'b0, a} + 5'd1;
            3'd3: return {1'b0, a} + 5'd15;
            3'd4: return {1'b1, a & b};
            3'd5: return {1'b1, a | b};
            3'd6: return {1'b1, a ^ b};
            default: return {1'b1, a[3], a[3:1]};
        endcase
    endfunction

    assign {alu_carry, alu_res} = alu_fn({s0, s1, s2}, alu_a, alu_b);
    assign {alu_carry_4, alu_res_4} = alu_fn({s0_4, s1_4, s2_4}, alu_a_4, alu_b_4);

    alu_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
        .res(res), .carry(carry), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s0(s0), .alu_s1(s1), .alu_s2(s2), .alu_res(alu_res), .alu_carry(alu_carry)
    );

    alu_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req0(q0), .req1(q1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0_4), .ack1(ack1_4),
        .res(res_4), .carry(carry_4), .busy(busy_4), .alu_a(alu_a_4), .alu_b(alu_b_4),
        .alu_s0(s0_4), .alu_s1(s1_4), .alu_s2(s2_4), .alu_res(alu_res_4), .alu_carry(alu_carry_4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("no_overlap", ack0 & ack1, 0);
            chk("no_overlap_4", ack0_4 & ack1_4, 0);
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; q0 = 1'b0; q1 = 1'b0;
        ptr_m = 1'b0;
        @(negedge clk);
        chk("rst_out", {ack0, ack1, res, carry, busy, alu_a, alu_b, s0, s1, s2}, 0);
        chk("rst_out_4", {ack0_4, ack1_4, res_4, carry_4, busy_4, alu_a_4, alu_b_4, s0_4, s1_4, s2_4}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        repeat (30) begin
            @(posedge clk); #1;
            n++;
            if (ack0 | ack1) return;
        end
        chk("ack_seen", ack0 | ack1, 1);
    endtask

    task automatic issue(input bit r0, input bit r1, input logic [2:0] o0, input logic [2:0] o1,
                         input logic [3:0] x0, input logic [3:0] y0, input logic [3:0] x1, input logic [3:0] y1);
        bit w;
        int n;
        logic [4:0] e;
        logic [2:0] wo;
        logic [3:0] wa, wb;
        op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1;
        req0 = r0; req1 = r1;
        w = (r0 && r1) ? ptr_m : r1;
        wo = w ? o1 : o0;
        wa = w ? x1 : x0;
        wb = w ? y1 : y0;
        e = alu_fn(wo, wa, wb);
        @(posedge clk); #1;
        chk("busy", busy, 1);
        chk("alu_ops", {alu_a, alu_b, s0, s1, s2}, {wa, wb, wo});
        op0 = 3'($urandom); op1 = 3'($urandom);
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        wait_ack(n);
        chk("latency", n, 1);
        chk("ack_owner", {ack0, ack1}, w ? 2'b01 : 2'b10);
        chk("res", res, e[3:0]);
        chk("carry", carry, wo[2] ? 1'b0 : e[4]);
        ptr_m = ~ptr_m;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        chk("ack_pulse", ack0 | ack1, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        int n;
        logic [4:0] e;
        logic [3:0] bb;
        logic [1:0] r;
        op0 = 3'd0; op1 = 3'd0; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        do_reset;
        repeat (2) @(posedge clk);
        #1;
        do_reset;

        issue(1, 0, 3'b000, 3'b000, 4'b1011, 4'b0010, 4'd0, 4'd0);
        chk("add_res", res, 4'b1101);
        chk("add_carry", carry, 0);

        do_reset;
        issue(1, 1, 3'b001, 3'b100, 4'b1011, 4'b0010, 4'b1011, 4'b0010);
        chk("sub_res", res, 4'b1001);
        chk("sub_carry", carry, 1);
        issue(0, 1, 3'b001, 3'b100, 4'b1011, 4'b0010, 4'b1011, 4'b0010);
        chk("and_res", res, 4'b0010);
        chk("and_carry", carry, 0);

        do_reset;
        op0 = 3'($urandom); op1 = 3'($urandom);
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            wait_ack(n);
            chk("alt_gap", n, i == 0 ? 1 : 3);
            chk("alt_owner", {ack0, ack1}, ptr_m ? 2'b01 : 2'b10);
            e = ptr_m ? alu_fn(op1, a1, b1) : alu_fn(op0, a0, b0);
            chk("alt_res", {carry, res}, {(ptr_m ? op1[2] : op0[2]) ? 1'b0 : e[4], e[3:0]});
            ptr_m = ~ptr_m;
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        op1 = 3'b110; a1 = 4'($urandom); b1 = 4'($urandom);
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        chk("abort_busy", busy, 1);
        do_reset;
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_ack", {ack0, ack1, busy}, 0);
            chk("abort_res", res, 0);
        end
        issue(1, 1, 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

        repeat (25) begin
            r = 2'($urandom_range(1, 3));
            issue(r[0], r[1], 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        bb = 4'($urandom);
        op1 = 3'b111; a1 = 4'b1011; b1 = bb;
        q1 = 1'b1;
        @(posedge clk); #1;
        q1 = 1'b0;
        n = 0;
        repeat (4) begin
            chk("settle4_ops", {alu_a_4, alu_b_4, s0_4, s1_4, s2_4}, {4'b1011, bb, 3'b111});
            chk("settle4_no_ack", {ack0_4, ack1_4}, 0);
            op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("asr_ack", {ack0_4, ack1_4, n[3:0]}, {2'b01, 4'd4});
        chk("asr_res", res_4, 4'b1101);
        chk("asr_carry", carry_4, 0);
        @(posedge clk); #1;
        chk("asr_ack_pulse", {ack0_4, ack1_4, busy_4}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
